// File: rtl/mire_writer_if.sv
// Wishbone write-master bundle between mire_writer and the SDRAM arbiter.
// Latency: none, wires only.
// Backpressure: the slave holds ack low to stall; the master keeps stb/adr/dat_ms stable.
// Ports: adr/dat_ms/we/sel/cti/bte/stb/cyc master->slave, ack slave->master.
interface mire_writer_if;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic        we;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        stb;
    logic        cyc;
    logic        ack;

    modport master (
        output adr, dat_ms, we, sel, cti, bte, stb, cyc,
        input  ack
    );

    modport slave (
        input  adr, dat_ms, we, sel, cti, bte, stb, cyc,
        output ack
    );
endinterface

// File: rtl/mire_writer.sv
// Wishbone master that continuously paints a 16-pixel white grid into the framebuffer.
// Latency: enable seen in IDLE -> stb on the next edge; each ack -> next word the following cycle.
// Backpressure: waits indefinitely for ack with outputs frozen; releases cyc for one cycle every BURST words.
// Ports: wshb_clk/wshb_rst_n (sync active-low), enable, wb (Wishbone master), frame_done (pulse after last pixel ack).
module mire_writer #(
    parameter int          HDISP = 800,
    parameter int          VDISP = 480,
    parameter int          BURST = 64,
    parameter logic [31:0] BASE  = 32'd0
) (
    input  logic          wshb_clk,
    input  logic          wshb_rst_n,
    input  logic          enable,
    mire_writer_if.master wb,
    output logic          frame_done
);

    localparam int XW = $clog2(HDISP);
    localparam int YW = $clog2(VDISP);
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [CW-1:0]  word_cnt;
    logic [31:0]    adr_q;
    logic [31:0]    dat_q;

    logic           xfer;
    logic           x_last;
    logic           y_last;
    logic           frame_last;
    logic           burst_end;
    logic [XW-1:0]  x_nxt;
    logic [YW-1:0]  y_nxt;

    // White on every 16th column and every 16th row, black elsewhere.
    function automatic logic [31:0] pattern(input logic [XW-1:0] xv, input logic [YW-1:0] yv);
        if (((32'(xv) & 32'd15) == 32'd0) || ((32'(yv) & 32'd15) == 32'd0))
            return 32'h00FF_FFFF;
        return 32'h0000_0000;
    endfunction

    assign xfer       = (state == WRITE) && wb.ack;
    assign x_last     = (x == XW'(HDISP - 1));
    assign y_last     = (y == YW'(VDISP - 1));
    assign frame_last = x_last && y_last;
    assign burst_end  = (word_cnt == CW'(BURST - 1));

    always_comb begin
        x_nxt = x + XW'(1);
        y_nxt = y;
        if (x_last) begin
            x_nxt = '0;
            y_nxt = y_last ? '0 : y + YW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable)
                    state_nxt = WRITE;
            end
            WRITE: begin
                if (xfer) begin
                    if (burst_end)
                        state_nxt = PAUSE;
                    else if (!enable)
                        state_nxt = IDLE;
                end
            end
            PAUSE: begin
                state_nxt = enable ? WRITE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wshb_clk) begin
        if (!wshb_rst_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            word_cnt   <= '0;
            adr_q      <= BASE;
            dat_q      <= 32'd0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= xfer && frame_last;
            if (xfer) begin
                x        <= x_nxt;
                y        <= y_nxt;
                word_cnt <= burst_end ? '0 : word_cnt + CW'(1);
                // Pixels are stored linearly, so the address just steps by one word
                // and snaps back to BASE on the frame wrap.
                adr_q    <= frame_last ? BASE : adr_q + 32'd4;
                dat_q    <= pattern(x_nxt, y_nxt);
            end else if (state == IDLE && enable) begin
                // Data is cleared by reset, so reload it before the first strobe.
                dat_q    <= pattern(x, y);
            end
        end
    end

    assign wb.adr    = adr_q;
    assign wb.dat_ms = dat_q;
    assign wb.we     = 1'b1;
    assign wb.sel    = 4'b1111;
    assign wb.cti    = 3'b000;
    assign wb.bte    = 2'b00;
    assign wb.stb    = (state == WRITE);
    assign wb.cyc    = (state == WRITE);

endmodule

// File: tb/tb_mire_writer.sv
// Self-checking bench for mire_writer on a small 32x4 frame with 8-word bursts.
// Latency: outputs sampled on the falling edge, inputs driven on the falling edge.
// Backpressure: the bench plays the slave, stalling ack in directed and random patterns.
module tb_mire_writer;

    localparam int          HDISP = 32;
    localparam int          VDISP = 4;
    localparam int          BURST = 8;
    localparam logic [31:0] BASE  = 32'd0;
    localparam int          NPIX  = HDISP * VDISP;

    logic clk = 1'b0;
    logic wshb_rst_n;
    logic enable;
    logic frame_done;

    mire_writer_if bus ();

    mire_writer #(
        .HDISP (HDISP),
        .VDISP (VDISP),
        .BURST (BURST),
        .BASE  (BASE)
    ) dut (
        .wshb_clk   (clk),
        .wshb_rst_n (wshb_rst_n),
        .enable     (enable),
        .wb         (bus),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: which pixel is due next, words acked in this tenure,
    // whether the bus should be strobing, whether frame_done is due.
    int pix;
    int tenure;
    bit mdl_stb;
    bit mdl_fd;
    int frames_seen;
    logic [31:0] obs_16_1;
    logic [31:0] obs_5_3;

    function automatic logic [31:0] pat(input int p);
        int px;
        int py;
        px = p % HDISP;
        py = p / HDISP;
        return ((px % 16 == 0) || (py % 16 == 0)) ? 32'h00FF_FFFF : 32'h0000_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pix     = 0;
        tenure  = 0;
        mdl_stb = 0;
        mdl_fd  = 0;
    endtask

    // Compare the current outputs against the model, drive the next inputs,
    // advance the model by one clock and move to the next falling edge.
    task automatic step(input bit a, input bit en, input bit rn);
        bit fd_next;
        check("stb", {31'd0, bus.stb}, {31'd0, mdl_stb});
        check("cyc", {31'd0, bus.cyc}, {31'd0, mdl_stb});
        check("frame_done", {31'd0, frame_done}, {31'd0, mdl_fd});
        if (mdl_stb) begin
            check("adr", bus.adr, BASE + 32'(4 * pix));
            check("dat_ms", bus.dat_ms, pat(pix));
            if (pix == 1 * HDISP + 16) obs_16_1 = bus.dat_ms;
            if (pix == 3 * HDISP + 5)  obs_5_3  = bus.dat_ms;
        end
        if (mdl_fd) frames_seen++;

        bus.ack    = a;
        enable     = en;
        wshb_rst_n = rn;

        if (!rn) begin
            model_reset();
        end else begin
            fd_next = 0;
            if (mdl_stb) begin
                if (a) begin
                    fd_next = (pix == NPIX - 1);
                    pix     = (pix + 1) % NPIX;
                    tenure++;
                    if (tenure == BURST) begin
                        tenure  = 0;
                        mdl_stb = 0;
                    end else if (!en) begin
                        mdl_stb = 0;
                    end
                end
            end else begin
                mdl_stb = en;
            end
            mdl_fd = fd_next;
        end
        @(negedge clk);
    endtask

    initial begin
        frames_seen = 0;
        obs_16_1    = 'x;
        obs_5_3     = 'x;
        wshb_rst_n  = 1'b0;
        enable      = 1'b0;
        bus.ack     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_stb", {31'd0, bus.stb}, 32'd0);
        check("rst_cyc", {31'd0, bus.cyc}, 32'd0);
        check("rst_adr", bus.adr, BASE);
        check("rst_dat", bus.dat_ms, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);

        // Release reset while idle, then ack every cycle for a full frame and a bit.
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 160; i++) step(1'b1, 1'b1, 1'b1);
        check("frames_after_full_run", 32'(frames_seen), 32'd1);
        check("pixel_16_1", obs_16_1, 32'h00FF_FFFF);
        check("pixel_5_3", obs_5_3, 32'h0000_0000);

        // Ack delayed by 5 cycles, several times.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
            step(1'b1, 1'b1, 1'b1);
        end

        // Drop enable with an ack pending, then resume.
        for (int i = 0; i < 4 && !mdl_stb; i++) step(1'b0, 1'b1, 1'b1);
        check("stb_before_drop", {31'd0, bus.stb}, 32'd1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1);

        // Random ack and enable, long enough to wrap frames several times.
        for (int i = 0; i < 1200; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, 1'b1);
        check("frames_seen_random", 32'(frames_seen > 3), 32'd1);

        // Reset mid-burst with an ack pending.
        for (int i = 0; i < 20 && !mdl_stb; i++) step(1'b0, 1'b1, 1'b1);
        check("stb_before_reset", {31'd0, bus.stb}, 32'd1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("rst_mid_adr", bus.adr, BASE);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) step($urandom_range(0, 1) != 0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
